// File: rtl/csr_file.sv
// Purpose : LoongArch-style control/status register file with an optional countdown timer (macro CSR_TIMER_EN).
// Latency : reads are combinational from inst_addr; writes commit on the next clk edge; rd_csr/ti_out are registered.
// Backpress: none -- every read/write strobe is accepted in the cycle it is presented; no stall path exists.

package csr_pkg;

    typedef struct packed {
        logic        we;
        logic [31:0] crmd;
        logic [31:0] prmd;
        logic [31:0] estat;
        logic [31:0] era;
        logic [31:0] badv;
    } excp_wr_csr_req_t;

    typedef struct packed {
        logic [31:0] crmd;
        logic [31:0] prmd;
        logic [31:0] ecfg;
        logic [31:0] estat;
        logic [31:0] era;
        logic [31:0] badv;
        logic [31:0] eentry;
        logic [31:0] save0;
        logic [31:0] save1;
        logic [31:0] save2;
        logic [31:0] save3;
        logic [31:0] tid;
        logic [31:0] tcfg;
        logic [31:0] tval;
        logic [31:0] tlbrentry;
    } csr_t;

    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ECFG      = 14'h004;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00C;
    localparam logic [13:0] CSR_SAVE0     = 14'h030;
    localparam logic [13:0] CSR_SAVE1     = 14'h031;
    localparam logic [13:0] CSR_SAVE2     = 14'h032;
    localparam logic [13:0] CSR_SAVE3     = 14'h033;
    localparam logic [13:0] CSR_TID       = 14'h040;
    localparam logic [13:0] CSR_TCFG      = 14'h041;
    localparam logic [13:0] CSR_TVAL      = 14'h042;
    localparam logic [13:0] CSR_TICLR     = 14'h044;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

    // Architecturally writable bits per register.
    localparam logic [31:0] WMASK_CRMD   = 32'h0000_01FF;
    localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
    localparam logic [31:0] WMASK_ESTAT  = 32'h0000_0003;
    localparam logic [31:0] WMASK_ENTRY  = 32'hFFFF_FFC0;
    localparam logic [31:0] WMASK_FULL   = 32'hFFFF_FFFF;

    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

endpackage

module csr_file #(
    parameter int TIMER_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_re,
    input  logic [13:0]               inst_addr,
    output logic [31:0]               inst_rdata,
    input  logic                      inst_we,
    input  logic [31:0]               inst_wdata,
    input  logic [31:0]               inst_wmask,
    input  csr_pkg::excp_wr_csr_req_t excp_wr_req,
    output csr_pkg::csr_t             rd_csr,
    input  logic [7:0]                hwi_in,
    output logic                      ti_out
);
    import csr_pkg::*;

    // old/new merge restricted to the bits software may actually change
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] wdata,
                                          input logic [31:0] wmask,
                                          input logic [31:0] field);
        logic [31:0] m;
        m = wmask & field;
        return (old_v & ~m) | (wdata & m);
    endfunction

    logic [31:0] crmd_q, crmd_d;
    logic [31:0] prmd_q, prmd_d;
    logic [31:0] ecfg_q, ecfg_d;
    logic [31:0] estat_q, estat_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] eentry_q, eentry_d;
    logic [31:0] save0_q, save0_d;
    logic [31:0] save1_q, save1_d;
    logic [31:0] save2_q, save2_d;
    logic [31:0] save3_q, save3_d;
    logic [31:0] tlbrentry_q, tlbrentry_d;

    // next value of the timer-interrupt flag, mirrored into ESTAT.is[11]
    logic        timer_flag_d;
    logic [31:0] tid_view;
    logic [31:0] tcfg_view;
    logic [31:0] tval_view;

    // inst_re carries no side effects here: reads are pure address decode
    logic unused_sigs;
    assign unused_sigs = ^{inst_re, 32'(TIMER_W)};

`ifdef CSR_TIMER_EN
    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_DONE  = 2'd2
    } tmr_state_e;

    tmr_state_e          tst_q, tst_d;
    logic [31:0]         tid_q, tid_d;
    logic [TIMER_W-1:0]  tcfg_q, tcfg_d;
    logic [TIMER_W-1:0]  tval_q, tval_d;
    logic [TIMER_W-1:0]  tcfg_new;
    logic                timer_flag_q;
    logic                tcfg_wr;
    logic                ticlr_wr;
    logic                expire;

    assign tcfg_wr  = inst_we && (inst_addr == CSR_TCFG);
    assign ticlr_wr = inst_we && (inst_addr == CSR_TICLR) && inst_wdata[0] && inst_wmask[0];
    assign tcfg_new = (tcfg_q & ~inst_wmask[TIMER_W-1:0])
                    | (inst_wdata[TIMER_W-1:0] & inst_wmask[TIMER_W-1:0]);

    // timer state, count, config and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tst_q        <= T_IDLE;
            tid_q        <= '0;
            tcfg_q       <= '0;
            tval_q       <= '0;
            timer_flag_q <= 1'b0;
        end else begin
            tst_q        <= tst_d;
            tid_q        <= tid_d;
            tcfg_q       <= tcfg_d;
            tval_q       <= tval_d;
            timer_flag_q <= timer_flag_d;
        end
    end

    // timer next state: a TCFG write restarts everything, otherwise count/expire/reload
    always_comb begin
        tst_d   = tst_q;
        tcfg_d  = tcfg_q;
        tval_d  = tval_q;
        tid_d   = tid_q;
        expire  = 1'b0;
        if (inst_we && (inst_addr == CSR_TID)) begin
            tid_d = merge(tid_q, inst_wdata, inst_wmask, WMASK_FULL);
        end
        if (tcfg_wr) begin
            tcfg_d = tcfg_new;
            tval_d = {tcfg_new[TIMER_W-1:2], 2'b00};
            tst_d  = tcfg_new[0] ? T_COUNT : T_IDLE;
        end else begin
            case (tst_q)
                T_COUNT: begin
                    if (tval_q != '0) begin
                        tval_d = tval_q - TIMER_W'(1);
                    end else begin
                        expire = 1'b1;
                        if (tcfg_q[1]) begin
                            tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
                        end else begin
                            tst_d = T_DONE;
                        end
                    end
                end
                default: begin
                    tst_d = tst_q;
                end
            endcase
        end
        // an expiry in the same cycle as a clear must leave the flag set
        if (expire) begin
            timer_flag_d = 1'b1;
        end else if (ticlr_wr) begin
            timer_flag_d = 1'b0;
        end else begin
            timer_flag_d = timer_flag_q;
        end
    end

    assign tid_view  = tid_q;
    assign tcfg_view = 32'(tcfg_q);
    assign tval_view = 32'(tval_q);
    assign ti_out    = timer_flag_q;
`else
    assign timer_flag_d = 1'b0;
    assign tid_view     = '0;
    assign tcfg_view    = '0;
    assign tval_view    = '0;
    assign ti_out       = 1'b0;
`endif

    // core CSR storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crmd_q      <= CRMD_RESET;
            prmd_q      <= '0;
            ecfg_q      <= '0;
            estat_q     <= '0;
            era_q       <= '0;
            badv_q      <= '0;
            eentry_q    <= '0;
            save0_q     <= '0;
            save1_q     <= '0;
            save2_q     <= '0;
            save3_q     <= '0;
            tlbrentry_q <= '0;
        end else begin
            crmd_q      <= crmd_d;
            prmd_q      <= prmd_d;
            ecfg_q      <= ecfg_d;
            estat_q     <= estat_d;
            era_q       <= era_d;
            badv_q      <= badv_d;
            eentry_q    <= eentry_d;
            save0_q     <= save0_d;
            save1_q     <= save1_d;
            save2_q     <= save2_d;
            save3_q     <= save3_d;
            tlbrentry_q <= tlbrentry_d;
        end
    end

    // core CSR next state: software write, then exception override, then interrupt sampling
    always_comb begin
        crmd_d      = crmd_q;
        prmd_d      = prmd_q;
        ecfg_d      = ecfg_q;
        estat_d     = estat_q;
        era_d       = era_q;
        badv_d      = badv_q;
        eentry_d    = eentry_q;
        save0_d     = save0_q;
        save1_d     = save1_q;
        save2_d     = save2_q;
        save3_d     = save3_q;
        tlbrentry_d = tlbrentry_q;
        if (inst_we) begin
            case (inst_addr)
                CSR_CRMD:      crmd_d      = merge(crmd_q,      inst_wdata, inst_wmask, WMASK_CRMD);
                CSR_PRMD:      prmd_d      = merge(prmd_q,      inst_wdata, inst_wmask, WMASK_PRMD);
                CSR_ECFG:      ecfg_d      = merge(ecfg_q,      inst_wdata, inst_wmask, WMASK_ECFG);
                CSR_ESTAT:     estat_d     = merge(estat_q,     inst_wdata, inst_wmask, WMASK_ESTAT);
                CSR_ERA:       era_d       = merge(era_q,       inst_wdata, inst_wmask, WMASK_FULL);
                CSR_BADV:      badv_d      = merge(badv_q,      inst_wdata, inst_wmask, WMASK_FULL);
                CSR_EENTRY:    eentry_d    = merge(eentry_q,    inst_wdata, inst_wmask, WMASK_ENTRY);
                CSR_SAVE0:     save0_d     = merge(save0_q,     inst_wdata, inst_wmask, WMASK_FULL);
                CSR_SAVE1:     save1_d     = merge(save1_q,     inst_wdata, inst_wmask, WMASK_FULL);
                CSR_SAVE2:     save2_d     = merge(save2_q,     inst_wdata, inst_wmask, WMASK_FULL);
                CSR_SAVE3:     save3_d     = merge(save3_q,     inst_wdata, inst_wmask, WMASK_FULL);
                CSR_TLBRENTRY: tlbrentry_d = merge(tlbrentry_q, inst_wdata, inst_wmask, WMASK_ENTRY);
                default:       ;
            endcase
        end
        // exception entry/return owns these five registers outright
        if (excp_wr_req.we) begin
            crmd_d  = excp_wr_req.crmd;
            prmd_d  = excp_wr_req.prmd;
            estat_d = excp_wr_req.estat;
            era_d   = excp_wr_req.era;
            badv_d  = excp_wr_req.badv;
        end
        // interrupt pending bits always track their sources
        estat_d[9:2] = hwi_in;
        estat_d[11]  = timer_flag_d;
    end

    // combinational read decode; unimplemented numbers return zero
    always_comb begin
        inst_rdata = '0;
        case (inst_addr)
            CSR_CRMD:      inst_rdata = crmd_q;
            CSR_PRMD:      inst_rdata = prmd_q;
            CSR_ECFG:      inst_rdata = ecfg_q;
            CSR_ESTAT:     inst_rdata = estat_q;
            CSR_ERA:       inst_rdata = era_q;
            CSR_BADV:      inst_rdata = badv_q;
            CSR_EENTRY:    inst_rdata = eentry_q;
            CSR_SAVE0:     inst_rdata = save0_q;
            CSR_SAVE1:     inst_rdata = save1_q;
            CSR_SAVE2:     inst_rdata = save2_q;
            CSR_SAVE3:     inst_rdata = save3_q;
            CSR_TID:       inst_rdata = tid_view;
            CSR_TCFG:      inst_rdata = tcfg_view;
            CSR_TVAL:      inst_rdata = tval_view;
            CSR_TLBRENTRY: inst_rdata = tlbrentry_q;
            default:       inst_rdata = '0;
        endcase
    end

    assign rd_csr.crmd      = crmd_q;
    assign rd_csr.prmd      = prmd_q;
    assign rd_csr.ecfg      = ecfg_q;
    assign rd_csr.estat     = estat_q;
    assign rd_csr.era       = era_q;
    assign rd_csr.badv      = badv_q;
    assign rd_csr.eentry    = eentry_q;
    assign rd_csr.save0     = save0_q;
    assign rd_csr.save1     = save1_q;
    assign rd_csr.save2     = save2_q;
    assign rd_csr.save3     = save3_q;
    assign rd_csr.tid       = tid_view;
    assign rd_csr.tcfg      = tcfg_view;
    assign rd_csr.tval      = tval_view;
    assign rd_csr.tlbrentry = tlbrentry_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: table of write/read vectors plus hand sequences
// for exception collisions, interrupt sampling, the timer and mid-run reset.
// Timer sequences are selected by CSR_TIMER_EN to match the build of the DUT.

module tb_csr_file;
    import csr_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             inst_re;
    logic [13:0]      inst_addr;
    logic [31:0]      inst_rdata;
    logic             inst_we;
    logic [31:0]      inst_wdata;
    logic [31:0]      inst_wmask;
    excp_wr_csr_req_t excp_wr_req;
    csr_t             rd_csr;
    logic [7:0]       hwi_in;
    logic             ti_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    csr_file #(.TIMER_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_re     (inst_re),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_we     (inst_we),
        .inst_wdata  (inst_wdata),
        .inst_wmask  (inst_wmask),
        .excp_wr_req (excp_wr_req),
        .rd_csr      (rd_csr),
        .hwi_in      (hwi_in),
        .ti_out      (ti_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [13:0] addr, input logic [31:0] wdata,
                       input logic [31:0] wmask, input logic [31:0] exp, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    // one software write committed on the following rising edge; returns 1ns after it
    task automatic sw_write(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        inst_we = 1'b1; inst_addr = a; inst_wdata = d; inst_wmask = m;
        @(posedge clk);
        #1;
        inst_we = 1'b0; inst_wdata = '0; inst_wmask = '0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] v);
        @(negedge clk);
        inst_addr = a; inst_re = 1'b1;
        #1;
        v = inst_rdata;
        inst_re = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          hi;

        rst = 1'b1; inst_re = 1'b0; inst_addr = '0; inst_we = 1'b0;
        inst_wdata = '0; inst_wmask = '0; excp_wr_req = '0; hwi_in = '0;

        #2;
        check("reset_crmd", rd_csr.crmd, 32'h8);
        check("reset_era", rd_csr.era, 32'h0);
        check("reset_tval", rd_csr.tval, 32'h0);
        check("reset_ti", 32'(ti_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // csrxchg: old value visible before the edge, merged value after it
        @(negedge clk);
        inst_we = 1'b1; inst_addr = CSR_CRMD; inst_wdata = 32'h7; inst_wmask = 32'h4;
        #1;
        check("xchg_rdata_pre", inst_rdata, 32'h8);
        @(posedge clk);
        #1;
        inst_we = 1'b0; inst_wdata = '0; inst_wmask = '0;
        check("xchg_crmd_post", rd_csr.crmd, 32'hC);

        add(1'b0, CSR_CRMD,      32'h0,        32'h0,        32'h0000_000C, "crmd_read");
        add(1'b1, CSR_CRMD,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_01FF, "crmd_full");
        add(1'b1, CSR_CRMD,      32'h0,        32'h0000_000F, 32'h0000_01F0, "crmd_mask");
        add(1'b1, CSR_PRMD,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007, "prmd_full");
        add(1'b1, CSR_ECFG,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF, "ecfg_full");
        add(1'b1, CSR_ECFG,      32'h0,        32'h0000_0003, 32'h0000_1BFC, "ecfg_mask");
        add(1'b1, CSR_ESTAT,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, "estat_sw");
        add(1'b1, CSR_ERA,       32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, "era_full");
        add(1'b1, CSR_BADV,      32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, "badv_full");
        add(1'b1, CSR_EENTRY,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0, "eentry_align");
        add(1'b1, CSR_SAVE0,     32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hA5A5_A5A5, "save0_full");
        add(1'b1, CSR_SAVE3,     32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, "save3_mask");
        add(1'b1, CSR_TLBRENTRY, 32'h1C00_007F, 32'hFFFF_FFFF, 32'h1C00_0040, "tlbrentry_align");
        add(1'b1, 14'h008,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         "unimpl_zero");
        add(1'b1, CSR_TVAL,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         "tval_readonly");
        add(1'b1, CSR_TICLR,     32'h1,        32'hFFFF_FFFF, 32'h0,         "ticlr_reads0");
`ifdef CSR_TIMER_EN
        add(1'b1, CSR_TID,       32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, "tid_full");
`else
        add(1'b1, CSR_TID,       32'h1234_5678, 32'hFFFF_FFFF, 32'h0,         "tid_absent");
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we) sw_write(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
            rd(tbl[i].addr, v);
            check(tbl[i].name, v, tbl[i].exp);
        end

        // hardware interrupt lines land in ESTAT.is[9:2] next to the software bits
        @(negedge clk);
        hwi_in = 8'hA5;
        step(1);
        check("estat_hwi", rd_csr.estat, 32'h0000_0297);

        // exception write collides with a software ERA write: exception wins
        @(negedge clk);
        excp_wr_req.we = 1'b1; excp_wr_req.crmd = 32'h3; excp_wr_req.prmd = 32'h5;
        excp_wr_req.estat = 32'h000B_0000; excp_wr_req.era = 32'h1C00_0100; excp_wr_req.badv = 32'h44;
        inst_we = 1'b1; inst_addr = CSR_ERA; inst_wdata = 32'h55; inst_wmask = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        inst_we = 1'b0; excp_wr_req.we = 1'b0;
        check("collide_era", rd_csr.era, 32'h1C00_0100);
        check("excp_crmd", rd_csr.crmd, 32'h3);
        check("excp_prmd", rd_csr.prmd, 32'h5);
        check("excp_estat", rd_csr.estat, 32'h000B_0294);
        check("excp_badv", rd_csr.badv, 32'h44);

        // exception write alongside a software write to a non-exception CSR: both commit
        @(negedge clk);
        excp_wr_req.we = 1'b1; excp_wr_req.crmd = 32'h1;
        inst_we = 1'b1; inst_addr = CSR_SAVE1; inst_wdata = 32'h77; inst_wmask = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        inst_we = 1'b0; excp_wr_req.we = 1'b0;
        check("excp_save1", rd_csr.save1, 32'h77);
        check("excp_crmd2", rd_csr.crmd, 32'h1);

`ifdef CSR_TIMER_EN
        // one-shot: TCFG=0x9 -> TVAL 8..0, flag exactly 9 edges after the write
        sw_write(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
        check("os_tval_load", rd_csr.tval, 32'd8);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("os_tval_count", rd_csr.tval, 32'(8 - k));
            check("os_ti_low", 32'(ti_out), 32'h0);
        end
        step(1);
        check("os_ti_fire", 32'(ti_out), 32'h1);
        check("os_estat11", 32'(rd_csr.estat[11]), 32'h1);
        check("os_tval_zero", rd_csr.tval, 32'h0);
        step(10);
        check("os_tval_hold", rd_csr.tval, 32'h0);
        sw_write(CSR_TICLR, 32'h1, 32'h1);
        check("os_ti_clear", 32'(ti_out), 32'h0);
        step(20);
        check("os_no_refire", 32'(ti_out), 32'h0);

        // periodic: TCFG=0x7 -> TVAL=4, expiry every 5 edges
        sw_write(CSR_TCFG, 32'h7, 32'hFFFF_FFFF);
        check("per_tval_load", rd_csr.tval, 32'd4);
        step(5);
        check("per_fire1", 32'(ti_out), 32'h1);
        check("per_reload", rd_csr.tval, 32'd4);
        sw_write(CSR_TICLR, 32'h1, 32'h1);
        check("per_clear", 32'(ti_out), 32'h0);
        check("per_tval3", rd_csr.tval, 32'd3);
        step(3);
        check("per_still_low", 32'(ti_out), 32'h0);
        check("per_tval0", rd_csr.tval, 32'd0);
        step(1);
        check("per_fire2", 32'(ti_out), 32'h1);
        sw_write(CSR_TICLR, 32'h1, 32'h1);
        check("per_clear2", 32'(ti_out), 32'h0);
        step(3);
        // this TICLR lands on the expiry edge: set beats clear
        sw_write(CSR_TICLR, 32'h1, 32'h1);
        check("collide_ticlr", 32'(ti_out), 32'h1);
        check("collide_tval", rd_csr.tval, 32'd4);
        step(2);
        check("mid_count_tval", rd_csr.tval, 32'd2);
`else
        sw_write(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
        rd(CSR_TCFG, v);
        check("tcfg_absent", v, 32'h0);
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (ti_out !== 1'b0 || rd_csr.estat[11] !== 1'b0) hi++;
        end
        check("ti_never_high", 32'(hi), 32'h0);
`endif

        // asynchronous reset in the middle of operation takes effect before any edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_crmd", rd_csr.crmd, 32'h8);
        check("arst_era", rd_csr.era, 32'h0);
        check("arst_tval", rd_csr.tval, 32'h0);
        check("arst_ti", 32'(ti_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (ti_out !== 1'b0 || rd_csr.tval !== 32'h0) hi++;
        end
        check("post_rst_quiet", 32'(hi), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter TIMER_W, default 32, width of the TCFG.initval and TVAL timer count (range 8..32).
REQ-002 Reset/clock: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-003 Software read: inst_re input 1 read strobe; inst_addr input 14 CSR number; inst_rdata output 32 read data.
REQ-004 Software write: inst_we input 1 write strobe; inst_wdata input 32 write value; inst_wmask input 32 bit mask (all ones for csrwr, rj value for csrxchg).
REQ-005 Exception-side write: excp_wr_req input excp_wr_csr_req_t carries we, crmd, prmd, estat, era, badv.
REQ-006 CSR view: rd_csr output csr_t carries registered copies of all implemented CSRs.
REQ-007 Interrupt sources: hwi_in input 8 hardware interrupt lines; ti_out output 1 timer interrupt level.

Function
REQ-008 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44, TLBRENTRY 0x88.
REQ-009 inst_rdata SHALL be combinational from inst_addr, and unimplemented addresses read 0.
REQ-010 A software write SHALL commit on the next clk edge as new = (old & ~mask) | (wdata & mask), with only architecturally writable fields updated.
REQ-011 Writable fields: CRMD[8:0]; PRMD[2:0]; ECFG.lie[12:0] except bit 10; ESTAT.is[1:0] only; ERA, BADV, SAVE0-3, TID full; EENTRY[31:6]; TLBRENTRY[31:6]; TCFG[TIMER_W-1:0].
REQ-012 When excp_wr_req.we=1, the CRMD, PRMD, ESTAT, ERA and BADV fields SHALL be loaded whole from excp_wr_req on the next edge.
REQ-013 An exception write SHALL override a software write in the same cycle for the five exception-owned CSRs, while software writes to other CSRs in that cycle commit.
REQ-014 Each cycle, ESTAT.is[9:2] SHALL register hwi_in, and ESTAT.is[11] SHALL equal the timer-interrupt flag, regardless of software or exception writes.
REQ-015 TCFG fields: en=bit0, periodic=bit1, initval=bits[TIMER_W-1:2].
REQ-016 A TCFG write SHALL load TVAL = {initval, 2'b00} on the same edge.
REQ-017 Timer state machine:
- IDLE (en=0): TVAL holds.
- COUNT (en=1, TVAL!=0): TVAL decrements by 1 per cycle.
- EXPIRE (en=1, TVAL==0): sets the flag. If periodic, TVAL reloads to {initval, 2'b00} and returns to COUNT. Otherwise it enters DONE.
- DONE: holds TVAL at 0 with no further expiries until the next TCFG write.
REQ-018 Writing TICLR with bit0=1 SHALL clear the timer flag; if an expiry occurs in the same cycle, the set wins. TICLR reads 0.
REQ-019 TVAL SHALL be read-only; software writes to it are ignored.
REQ-020 ti_out SHALL equal the registered timer flag, with no combinational path from inputs.
REQ-021 rd_csr SHALL reflect only committed register state, one cycle after any write.

Reset
REQ-022 On rst assertion, the block SHALL immediately reset:
- CRMD=0x00000008 (plv=0, ie=0, da=1).
- All other CSRs = 0, timer flag = 0, timer in IDLE.
- ti_out = 0.
REQ-023 An rst pulse mid-count SHALL abort the count, with no expiry afterwards until TCFG is rewritten.

Configuration
REQ-024 When macro CSR_TIMER_EN is defined, TID, TCFG, TVAL, TICLR and the timer state machine SHALL be implemented.
REQ-025 When CSR_TIMER_EN is undefined:
- Those addresses read 0 and ignore writes.
- ESTAT.is[11] stays 0 and ti_out is tied to 0.
- No timer flops are synthesized.

Verification
REQ-026 Reset: assert rst mid-operation -> CRMD=0x8, TVAL=0, ti_out=0 within the same cycle.
REQ-027 csrxchg: CRMD=0x8, then write wdata=0x7, wmask=0x4 -> CRMD=0xC next cycle, and inst_rdata before the edge = 0x8.
REQ-028 One-shot timer: write TCFG=0x9 (initval=2, en=1) -> TVAL counts 8..0, ti_out rises exactly 9 cycles after the write, and TVAL stays 0.
REQ-029 Periodic timer: write TCFG=0x7 -> ti_out set, TICLR=1 clears it, and expiry recurs every 5 cycles.
REQ-030 Collision: exception write of ERA=0x1C000100 and software write of ERA=0x55 in the same cycle -> ERA=0x1C000100, while a simultaneous TICLR clear plus expiry leaves ti_out=1.
REQ-031 With CSR_TIMER_EN undefined: write TCFG=0x9 -> reads 0, ti_out stays 0 for 100 cycles.
